eth_tx_arbiter: RTL and testbench



---
 rtl/eth_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level N-channel transmit arbiter in front of one MAC TX
// byte interface. A granted channel owns the MAC until its valid drops, then an
// IFG_CYCLES idle gap is forced before the next arbitration.
// Optional per-channel completed-frame counters: define ETH_TX_ARBITER_STATS_EN.
module eth_tx_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*8-1:0]     ch_data_i,
  input  logic [NUM_CH-1:0]       ch_valid_i,
  output logic [NUM_CH-1:0]       ch_ack_o,
  output logic [7:0]              mac_data_o,
  output logic                    mac_valid_o,
  input  logic                    mac_ack_i,
  output logic [NUM_CH-1:0]       grant_o,
  output logic                    busy_o
`ifdef ETH_TX_ARBITER_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] frame_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] GAP_LOAD = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] winner;
  logic [7:0]       gap_cnt;
  logic             any_req;
  logic             owner_valid;
  logic [7:0]       owner_data;
  logic             frame_end;

  assign any_req     = |ch_valid_i;
  assign owner_valid = ch_valid_i[grant_idx];
  assign owner_data  = ch_data_i[{grant_idx, 3'b000} +: 8];
  assign frame_end   = (state == ST_SEND) && !owner_valid;
  assign rr_next     = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  assign busy_o      = (state != ST_IDLE);

  // Winner search: scan starts at channel 0 (fixed) or at rr_ptr (round-robin)
  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      idx = (ARB_MODE == 1) ? ((int'(rr_ptr) + off) % NUM_CH) : off;
      if (!found && ch_valid_i[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  // MAC and channel-side outputs: transparent path from the owner during SEND
  always_comb begin
    mac_valid_o = 1'b0;
    mac_data_o  = '0;
    ch_ack_o    = '0;
    grant_o     = '0;
    if (state == ST_SEND) begin
      grant_o[grant_idx]  = 1'b1;
      mac_valid_o         = owner_valid;
      ch_ack_o[grant_idx] = mac_ack_i;
      if (owner_valid) begin
        mac_data_o = owner_data;
      end
    end
  end

  // Frame-level FSM: arbitrate in IDLE, hold owner through SEND, count down GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_idx <= winner;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!owner_valid) begin
            grant_idx <= '0;
            if (ARB_MODE == 1) begin
              rr_ptr <= rr_next;
            end
            if (IFG_CYCLES > 0) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ETH_TX_ARBITER_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] frame_cnt;

  assign frame_cnt_o = frame_cnt;

  // Completed-frame counters, bumped for the owner on its end-of-frame cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt[grant_idx] <= frame_cnt[grant_idx] + 1'b1;
    end
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: two arbiter instances driven by random frame senders.
//   unit 0: NUM_CH=2, fixed priority, IFG_CYCLES=12
//   unit 1: NUM_CH=3, round-robin,    IFG_CYCLES=0
// Expected outputs come from a frame-level reference model (owner / cooldown).
module tb_eth_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Stimulus storage, widest case (8 channels) for both units
  logic [63:0] din  [2];
  logic [7:0]  vin  [2];
  logic        mack [2];

  logic [1:0]  a_ack, a_grant;
  logic [7:0]  a_mdata;
  logic        a_mvalid, a_busy;
  logic [2:0]  b_ack, b_grant;
  logic [7:0]  b_mdata;
  logic        b_mvalid, b_busy;
`ifdef ETH_TX_ARBITER_STATS_EN
  logic [31:0] a_cnt;
  logic [47:0] b_cnt;
`endif

  eth_tx_arbiter #(.NUM_CH(2), .ARB_MODE(0), .IFG_CYCLES(12), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .ch_data_i(din[0][15:0]), .ch_valid_i(vin[0][1:0]), .ch_ack_o(a_ack),
    .mac_data_o(a_mdata), .mac_valid_o(a_mvalid), .mac_ack_i(mack[0]),
    .grant_o(a_grant), .busy_o(a_busy)
`ifdef ETH_TX_ARBITER_STATS_EN
    , .frame_cnt_o(a_cnt)
`endif
  );

  eth_tx_arbiter #(.NUM_CH(3), .ARB_MODE(1), .IFG_CYCLES(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .ch_data_i(din[1][23:0]), .ch_valid_i(vin[1][2:0]), .ch_ack_o(b_ack),
    .mac_data_o(b_mdata), .mac_valid_o(b_mvalid), .mac_ack_i(mack[1]),
    .grant_o(b_grant), .busy_o(b_busy)
`ifdef ETH_TX_ARBITER_STATS_EN
    , .frame_cnt_o(b_cnt)
`endif
  );

  // Unit configuration
  int n_ch [2] = '{2, 3};
  int mode [2] = '{0, 1};
  int ifg  [2] = '{12, 0};

  // Reference model: who owns the wire, idle cycles still owed, next RR start
  int owner [2];
  int cool  [2];
  int rr    [2];
  int fcnt  [2][8];

  // Sender state per channel
  int       rem    [2][8];
  int       wait_c [2][8];
  logic [7:0] cur_b [2][8];

  int checks = 0;
  int errors = 0;
  int reset_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 60)) : int'($urandom_range(1, 6));
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      owner[u] = -1;
      cool[u]  = 0;
      rr[u]    = 0;
      for (int k = 0; k < 8; k++) begin
        fcnt[u][k]   = 0;
        rem[u][k]    = 0;
        wait_c[u][k] = int'($urandom_range(1, 3));
        cur_b[u][k]  = 8'($urandom);
      end
    end
  endtask

  task automatic drive_inputs();
    for (int u = 0; u < 2; u++) begin
      din[u]  = {$urandom, $urandom};
      vin[u]  = '0;
      mack[u] = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < n_ch[u]; k++) begin
        if (rem[u][k] > 0) begin
          vin[u][k]           = 1'b1;
          din[u][k*8 +: 8]    = cur_b[u][k];
        end
      end
    end
  endtask

  // Compare both DUTs against the model, then advance the model one clock
  task automatic check_and_step();
    logic [7:0] e_ack, e_grant, e_data, g_ack, g_grant, g_data;
    logic       e_valid, e_busy, g_valid, g_busy;
    int         o;
    for (int u = 0; u < 2; u++) begin
      o       = owner[u];
      e_ack   = '0;
      e_grant = '0;
      e_data  = '0;
      e_valid = 1'b0;
      e_busy  = (o >= 0) || (cool[u] > 0);
      if (o >= 0) begin
        e_grant[o] = 1'b1;
        e_ack[o]   = mack[u];
        e_valid    = vin[u][o];
        if (e_valid) e_data = cur_b[u][o];
      end
      if (u == 0) begin
        g_ack = {6'b0, a_ack}; g_grant = {6'b0, a_grant}; g_data = a_mdata;
        g_valid = a_mvalid; g_busy = a_busy;
      end else begin
        g_ack = {5'b0, b_ack}; g_grant = {5'b0, b_grant}; g_data = b_mdata;
        g_valid = b_mvalid; g_busy = b_busy;
      end
      check($sformatf("u%0d mac_valid", u), 64'(g_valid), 64'(e_valid));
      check($sformatf("u%0d mac_data", u),  64'(g_data),  64'(e_data));
      check($sformatf("u%0d ch_ack", u),    64'(g_ack),   64'(e_ack));
      check($sformatf("u%0d grant", u),     64'(g_grant), 64'(e_grant));
      check($sformatf("u%0d busy", u),      64'(g_busy),  64'(e_busy));
`ifdef ETH_TX_ARBITER_STATS_EN
      for (int k = 0; k < n_ch[u]; k++) begin
        check($sformatf("u%0d frame_cnt%0d", u, k),
              (u == 0) ? 64'(a_cnt[k*16 +: 16]) : 64'(b_cnt[k*16 +: 16]),
              64'(fcnt[u][k] % 65536));
      end
`endif

      // Arbiter model advance
      if (o >= 0) begin
        if (!vin[u][o]) begin
          fcnt[u][o]++;
          rr[u]    = (o + 1) % n_ch[u];
          owner[u] = -1;
          cool[u]  = ifg[u];
        end
      end else if (cool[u] > 0) begin
        cool[u]--;
      end else if (vin[u] != 0) begin
        for (int s = 0; s < n_ch[u]; s++) begin
          int k;
          k = (mode[u] == 1) ? (rr[u] + s) % n_ch[u] : s;
          if (owner[u] < 0 && vin[u][k]) owner[u] = k;
        end
      end

      // Sender advance: byte consumed on ack while owning and valid
      for (int k = 0; k < n_ch[u]; k++) begin
        if (rem[u][k] > 0) begin
          if (o == k && vin[u][k] && mack[u]) begin
            rem[u][k]--;
            cur_b[u][k]++;
            if (rem[u][k] == 0) wait_c[u][k] = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, 20));
          end
        end else if (wait_c[u][k] > 1) begin
          wait_c[u][k]--;
        end else begin
          rem[u][k]   = frame_len();
          cur_b[u][k] = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      din[u] = '0; vin[u] = '0; mack[u] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #2;
    check("reset a_mvalid", 64'(a_mvalid), 64'd0);
    check("reset a_mdata",  64'(a_mdata),  64'd0);
    check("reset a_grant",  64'(a_grant),  64'd0);
    check("reset a_busy",   64'(a_busy),   64'd0);
    check("reset b_ack",    64'(b_ack),    64'd0);
    check("reset b_busy",   64'(b_busy),   64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1 drive_inputs();
      @(negedge clk);
      check_and_step();
      // Asynchronous reset in the middle of a unit-0 frame, after a warm-up
      if (cyc > 3000 && reset_done == 0 && owner[0] >= 0 && rem[0][owner[0]] > 1) begin
        #1 rst_n = 1'b0;
        #1;
        check("midreset a_mvalid", 64'(a_mvalid), 64'd0);
        check("midreset a_grant",  64'(a_grant),  64'd0);
        check("midreset a_busy",   64'(a_busy),   64'd0);
        check("midreset a_ack",    64'(a_ack),    64'd0);
        check("midreset b_mvalid", 64'(b_mvalid), 64'd0);
        check("midreset b_grant",  64'(b_grant),  64'd0);
`ifdef ETH_TX_ARBITER_STATS_EN
        check("midreset a_cnt", 64'(a_cnt), 64'd0);
`endif
        model_reset();
        drive_inputs();
        #1 rst_n = 1'b1;
        reset_done = 1;
      end
    end
    check("midframe reset reached", 64'(reset_done), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
